systolic_seq: RTL and testbench
===============================

Name: systolic_seq

Overview:
- Sequencer for the DIM x DIM systolic MAC array; sits between the host/DMA stream and the array ports.
- Runs three commands: LOAD_C (preload accumulators row by row), COMPUTE (skew and stream K A/B vectors, then drain), READ_C (stream C out in half-row beats).
- Owns all array control (en, WrEn, Crow, hl) and the diagonal input skew, so producers supply unskewed vectors.

Parameters:
- BITS_AB, 32, A/B element width.
- BITS_C, 32, C element width.
- DIM, 8, array dimension; even, and must equal the array's DIM (the array's hl demux is built for 8).
- LEN_W, 8, width of cmd_len; max K = 2^LEN_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0 LOAD_C, 1 COMPUTE, 2 READ_C, 3 reserved
- cmd_len  in  LEN_W  K for COMPUTE; ignored otherwise
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- in_a  in  BITS_AB x DIM  A column vector (element r -> row r)
- in_b  in  BITS_AB x DIM  B row vector (element c -> col c)
- in_c  in  BITS_C x DIM  C row for LOAD_C
- out_valid  out  1  READ_C beat valid
- out_ready  in  1  consumer ready
- out_data  out  BITS_C x DIM/2  half row of C
- arr_en, arr_wren, arr_hl  out  1 each  array en/WrEn/hl
- arr_crow  out  clog2(DIM)  array Crow
- arr_a, arr_b  out  BITS_AB x DIM  skewed array inputs
- arr_cin  out  BITS_C x DIM  array Cin
- arr_cout  in  BITS_C x DIM/2  array Cout
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when op 3 is accepted

Behaviour:
- Reset (async): state IDLE; all counters and skew registers 0; arr_en, arr_wren, arr_hl, arr_crow, out_valid, done, err = 0. Reset mid-command aborts it with no done.
- States: IDLE, LOADC, FEED, DRAIN, READ.
- arr_en and arr_wren are never high in the same cycle.
- IDLE:
  - cmd_valid&cmd_ready accepts. op0 -> LOADC, row=0. op1 -> FEED, k=cmd_len. op2 -> READ, row=0, half=0.
  - op3 -> stay IDLE; err and done pulse next cycle.
  - COMPUTE with cmd_len=0 -> stay IDLE; done next cycle; arr_en never asserted.
- LOADC:
  - in_ready=1; arr_crow=row; arr_cin=in_c (combinational); arr_wren=in_valid; arr_en=0.
  - Each beat increments row. Beat with row=DIM-1 -> IDLE, done next cycle.
- FEED:
  - in_ready=1; arr_en=in_valid. No beat means arr_en=0 and the array and skew registers hold.
  - Skew: arr_a[r] = in_a[r] delayed r enabled stages; arr_b[c] = in_b[c] delayed c enabled stages; stage 0 is combinational. All skew registers advance only when arr_en=1.
  - After the K-th beat -> DRAIN, cnt=2*DIM-1.
- DRAIN:
  - in_ready=0; arr_en=1; skew inputs forced 0.
  - cnt decrements; at 1 -> IDLE, done next cycle.
  - 2*DIM-1 covers DIM-1 skew + DIM-1 hops + 1 MAC register, so C holds the full A*B+C at done.
- READ:
  - out_valid=1; arr_crow=row; arr_hl=half; out_data=arr_cout (combinational, stable while stalled since row/half hold).
  - On out_valid&out_ready: half toggles; row increments when half was 1.
  - After beat (row DIM-1, half 1) -> IDLE, done next cycle. Total 2*DIM beats, order row0 low, row0 high, row1 low, ...
- Back-to-back: a new command may be accepted the cycle done is high.

Optional Feature:
- SYSTOLIC_SEQ_PERF_EN defined: adds outputs perf_busy_cycles[31:0] (counts cycles busy=1) and perf_stall_cycles[31:0] (counts FEED cycles with in_valid=0, and READ cycles with out_valid&!out_ready). Both saturate at 2^32-1 and clear on reset only.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package systolic_pkg: op_e enum (OP_LOAD_C, OP_COMPUTE, OP_READ_C, OP_RSVD), state_e enum, localparam DRAIN_CYCLES = 2*DIM-1, CROW_W = $clog2(DIM).
- Sub-module skew_delay #(WIDTH, DEPTH): DEPTH enable-gated registers with async clear; DEPTH=0 is a wire. Instantiated 2*DIM times with DEPTH = lane index.

Test Plan:
- LOAD_C with in_c row i = {i*8+j}, in_valid every cycle -> arr_wren high 8 cycles, arr_crow 0..7, arr_en=0, done on 9th cycle.
- COMPUTE K=8 with A=B=identity after LOAD_C zeros, then READ_C -> 16 beats; C[i][i]=1, all other elements 0; done 8+15 cycles after the first beat.
- COMPUTE K=3 with in_valid toggling 1,0,1,0,1 -> arr_en mirrors in_valid; skew lanes hold on low cycles; result equals the unstalled run.
- READ_C with out_ready low for 5 cycles on beat 3 -> out_data and arr_crow/arr_hl stable; 16 beats total in order.
- cmd_op=3, then COMPUTE cmd_len=0 -> err+done pulse, then done alone; arr_en never high.
- rst_n low at DRAIN cnt=7 -> outputs 0 immediately; busy=0; no done; next LOAD_C is accepted normally.

Source files
------------

// File: rtl/systolic_seq_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and constants for the systolic MAC array sequencer.
//   op_e         : command opcodes carried on cmd_op
//   state_e      : sequencer FSM states
//   DIM_DEF      : array dimension the array's hl demux is built for
//   DRAIN_CYCLES : flush length for DIM_DEF (DIM-1 skew + DIM-1 hops + 1 MAC)
//   CROW_W       : Crow width for DIM_DEF
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int DIM_DEF      = 8;
   localparam int DRAIN_CYCLES = 2 * DIM_DEF - 1;
   localparam int CROW_W       = $clog2(DIM_DEF);

   typedef enum logic [1:0] {
      OP_LOAD_C  = 2'd0,
      OP_COMPUTE = 2'd1,
      OP_READ_C  = 2'd2,
      OP_RSVD    = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOADC = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_READ  = 3'd4
   } state_e;

endpackage

// File: rtl/systolic_seq_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_if
// Host/DMA side bundle of the sequencer: command, input-beat and read-out
// channels, each a valid/ready handshake.
//   cmd_*  : command channel (op, len = K for COMPUTE)
//   in_*   : unskewed A column / B row / C row beats
//   out_*  : half-row C beats for READ_C
// Modports: master = host (producer of commands and input beats, consumer of
// output beats); slave = sequencer.
// -----------------------------------------------------------------------------
interface systolic_seq_if #(
   parameter int BITS_AB = 32,
   parameter int BITS_C  = 32,
   parameter int DIM     = 8,
   parameter int LEN_W   = 8
);
   import systolic_pkg::*;

   logic                        cmd_valid;
   logic                        cmd_ready;
   op_e                         cmd_op;
   logic [LEN_W-1:0]            cmd_len;

   logic                        in_valid;
   logic                        in_ready;
   logic [DIM-1:0][BITS_AB-1:0] in_a;
   logic [DIM-1:0][BITS_AB-1:0] in_b;
   logic [DIM-1:0][BITS_C-1:0]  in_c;

   logic                          out_valid;
   logic                          out_ready;
   logic [DIM/2-1:0][BITS_C-1:0]  out_data;

   modport master (
      output cmd_valid, cmd_op, cmd_len,
      output in_valid, in_a, in_b, in_c,
      output out_ready,
      input  cmd_ready, in_ready, out_valid, out_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len,
      input  in_valid, in_a, in_b, in_c,
      input  out_ready,
      output cmd_ready, in_ready, out_valid, out_data
   );

endinterface

// File: rtl/systolic_seq_skew_delay.sv
// -----------------------------------------------------------------------------
// skew_delay
// DEPTH-stage delay line whose stages advance only when en is high; used to
// build the diagonal input skew of the systolic array. DEPTH = 0 is a plain
// wire (lane 0 of the array has no skew).
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear of all stages
//   en         : advance enable (array enable)
//   din        : lane input
//   dout       : din delayed by DEPTH enabled stages
// -----------------------------------------------------------------------------
module skew_delay #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         // Clock, reset and enable have no job in a zero-depth lane.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, en};
         assign dout        = din;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stage_reg <= '0;
            end else if (en) begin
               stage_reg[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_reg[i] <= stage_reg[i-1];
               end
            end
         end

         assign dout = stage_reg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
// Sequencer between the host/DMA stream and a DIM x DIM systolic MAC array.
// Runs LOAD_C (preload accumulators row by row), COMPUTE (skew and stream K
// A/B vectors, then drain) and READ_C (stream C out in half-row beats). It owns
// every array control line and the diagonal input skew, so producers hand in
// unskewed vectors.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : cmd_*, in_*, out_* handshake channels
//   arr_en/arr_wren : array MAC enable / C write enable (never both high)
//   arr_hl/arr_crow : array half-row select / C row select
//   arr_a, arr_b    : skewed A/B inputs to the array edges
//   arr_cin         : C row written on arr_wren
//   arr_cout        : half row of C selected by arr_crow/arr_hl
//   busy            : not idle
//   done            : one-cycle pulse after a command completes
//   err             : one-cycle pulse after a reserved op is accepted
// Optional build macro SYSTOLIC_SEQ_PERF_EN adds saturating counters
//   perf_busy_cycles  : cycles with busy high
//   perf_stall_cycles : FEED cycles without an input beat plus READ cycles
//                       held by the consumer
// -----------------------------------------------------------------------------
module systolic_seq
   import systolic_pkg::*;
#(
   parameter int BITS_AB = 32,
   parameter int BITS_C  = 32,
   parameter int DIM     = DIM_DEF,
   parameter int LEN_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   systolic_seq_if.slave                 bus,
   output logic                          arr_en,
   output logic                          arr_wren,
   output logic                          arr_hl,
   output logic [$clog2(DIM)-1:0]        arr_crow,
   output logic [DIM-1:0][BITS_AB-1:0]   arr_a,
   output logic [DIM-1:0][BITS_AB-1:0]   arr_b,
   output logic [DIM-1:0][BITS_C-1:0]    arr_cin,
   input  logic [DIM/2-1:0][BITS_C-1:0]  arr_cout,
   output logic                          busy,
   output logic                          done,
   output logic                          err
`ifdef SYSTOLIC_SEQ_PERF_EN
   ,
   output logic [31:0]                   perf_busy_cycles,
   output logic [31:0]                   perf_stall_cycles
`endif
);

   localparam int RW      = $clog2(DIM);
   localparam int DRAIN_N = 2 * DIM - 1;
   localparam int CNT_W   = (LEN_W > $clog2(DRAIN_N + 1)) ? LEN_W : $clog2(DRAIN_N + 1);

   localparam logic [RW-1:0]    ROW_LAST  = RW'(DIM - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DRAIN_N);

   state_e            state_reg, state_next;
   logic [RW-1:0]     row_reg, row_next;
   logic              half_reg, half_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;     // K beats left in FEED, flush cycles left in DRAIN
   logic              done_reg, done_next;
   logic              err_reg, err_next;

   logic [DIM-1:0][BITS_AB-1:0] skew_a_in;
   logic [DIM-1:0][BITS_AB-1:0] skew_b_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         row_reg   <= '0;
         half_reg  <= 1'b0;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         row_reg   <= row_next;
         half_reg  <= half_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      row_next      = row_reg;
      half_next     = half_reg;
      cnt_next      = cnt_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;

      bus.cmd_ready = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;

      arr_en        = 1'b0;
      arr_wren      = 1'b0;
      arr_hl        = 1'b0;
      arr_crow      = '0;
      arr_cin       = '0;

      // Skew lanes only see real data while feeding; zeros flush them in DRAIN.
      skew_a_in     = '0;
      skew_b_in     = '0;

      case (state_reg)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_LOAD_C: begin
                     state_next = ST_LOADC;
                     row_next   = '0;
                  end
                  OP_COMPUTE: begin
                     // K = 0 has nothing to stream: complete without touching the array.
                     if (bus.cmd_len == '0) begin
                        done_next = 1'b1;
                     end else begin
                        state_next = ST_FEED;
                        cnt_next   = CNT_W'(bus.cmd_len);
                     end
                  end
                  OP_READ_C: begin
                     state_next = ST_READ;
                     row_next   = '0;
                     half_next  = 1'b0;
                  end
                  OP_RSVD: begin
                     err_next  = 1'b1;
                     done_next = 1'b1;
                  end
               endcase
            end
         end

         ST_LOADC: begin
            bus.in_ready = 1'b1;
            arr_crow     = row_reg;
            arr_cin      = bus.in_c;
            arr_wren     = bus.in_valid;
            if (bus.in_valid) begin
               row_next = row_reg + 1'b1;
               if (row_reg == ROW_LAST) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end
            end
         end

         ST_FEED: begin
            bus.in_ready = 1'b1;
            arr_en       = bus.in_valid;
            skew_a_in    = bus.in_a;
            skew_b_in    = bus.in_b;
            if (bus.in_valid) begin
               cnt_next = cnt_reg - 1'b1;
               if (cnt_reg == CNT_ONE) begin
                  state_next = ST_DRAIN;
                  cnt_next   = CNT_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            arr_en   = 1'b1;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_ONE) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end

         ST_READ: begin
            bus.out_valid = 1'b1;
            arr_crow      = row_reg;
            arr_hl        = half_reg;
            bus.out_data  = arr_cout;
            if (bus.out_ready) begin
               half_next = ~half_reg;
               if (half_reg) begin
                  row_next = row_reg + 1'b1;
                  if (row_reg == ROW_LAST) begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Lane r of A and column c of B are delayed by r / c enabled stages.
   genvar gi;
   generate
      for (gi = 0; gi < DIM; gi++) begin : g_lane
         skew_delay #(
            .WIDTH (BITS_AB),
            .DEPTH (gi)
         ) u_skew_a (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (arr_en),
            .din   (skew_a_in[gi]),
            .dout  (arr_a[gi])
         );

         skew_delay #(
            .WIDTH (BITS_AB),
            .DEPTH (gi)
         ) u_skew_b (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (arr_en),
            .din   (skew_b_in[gi]),
            .dout  (arr_b[gi])
         );
      end
   endgenerate

   assign busy = (state_reg != ST_IDLE);
   assign done = done_reg;
   assign err  = err_reg;

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic stall_cycle;
   assign stall_cycle = ((state_reg == ST_FEED) && !bus.in_valid) ||
                        ((state_reg == ST_READ) && !bus.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (busy && (perf_busy_cycles != '1)) begin
            perf_busy_cycles <= perf_busy_cycles + 1'b1;
         end
         if (stall_cycle && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
// Self-checking bench for systolic_seq. A behavioural output-stationary MAC
// array sits on the arr_* ports; expected C values come from plain matrix
// arithmetic (C += a_col * b_row per accepted beat). READ_C expectations are
// queued when the command is issued and popped by an independent monitor.
// -----------------------------------------------------------------------------
module tb_systolic_seq;
   import systolic_pkg::*;

   localparam int BITS_AB = 32;
   localparam int BITS_C  = 32;
   localparam int DIM     = 8;
   localparam int LEN_W   = 8;
   localparam int CW      = 3;
   localparam int HD      = DIM / 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_seq_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .LEN_W(LEN_W)) bus ();

   logic                         arr_en, arr_wren, arr_hl;
   logic [CW-1:0]                arr_crow;
   logic [DIM-1:0][BITS_AB-1:0]  arr_a, arr_b;
   logic [DIM-1:0][BITS_C-1:0]   arr_cin;
   logic [HD-1:0][BITS_C-1:0]    arr_cout;
   logic                         busy, done, err;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

   systolic_seq #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .arr_en   (arr_en),
      .arr_wren (arr_wren),
      .arr_hl   (arr_hl),
      .arr_crow (arr_crow),
      .arr_a    (arr_a),
      .arr_b    (arr_b),
      .arr_cin  (arr_cin),
      .arr_cout (arr_cout),
      .busy     (busy),
      .done     (done),
      .err      (err)
`ifdef SYSTOLIC_SEQ_PERF_EN
      ,
      .perf_busy_cycles  (perf_busy_cycles),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   // ---------------- behavioural systolic array ----------------
   logic [31:0] pe_a [DIM][DIM];
   logic [31:0] pe_b [DIM][DIM];
   logic [31:0] pe_c [DIM][DIM];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               pe_a[i][j] <= '0;
               pe_b[i][j] <= '0;
            end
      end else if (arr_en) begin
         for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
               logic [31:0] ain, bin;
               if (j == 0) ain = arr_a[i]; else ain = pe_a[i][j-1];
               if (i == 0) bin = arr_b[j]; else bin = pe_b[i-1][j];
               pe_a[i][j] <= ain;
               pe_b[i][j] <= bin;
               pe_c[i][j] <= pe_c[i][j] + ain * bin;
            end
      end else if (arr_wren) begin
         for (int j = 0; j < DIM; j++) pe_c[arr_crow][j] <= arr_cin[j];
      end
   end

   always_comb begin
      arr_cout = '0;
      for (int j = 0; j < HD; j++)
         arr_cout[j] = pe_c[arr_crow][arr_hl ? j + HD : j];
   end

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      logic [HD-1:0][31:0] data;
      logic [CW-1:0]       row;
      logic                half;
   } beat_t;

   beat_t       exp_q [$];
   logic [31:0] c_exp [DIM][DIM];
   logic [31:0] ld    [DIM][DIM];
   int          n_chk = 0;
   int          n_fail = 0;
   int          en_cycles = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops one expected beat per accepted READ_C beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (arr_en) en_cycles++;
         chk("en_wren_exclusive", {127'd0, arr_en & arr_wren}, 128'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("read_unexpected_beat", 128'd1, 128'd0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("read_data", bus.out_data, e.data);
               chk("read_crow", arr_crow, e.row);
               chk("read_hl",   arr_hl,   e.half);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input op_e op, input int len);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = LEN_W'(len);
      #1;
      while (!bus.cmd_ready && n < 50) begin
         tick();
         n++;
      end
      chk("cmd_ready", bus.cmd_ready, 1);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic do_load();
      issue(OP_LOAD_C, 0);
      for (int r = 0; r < DIM; r++) begin
         bus.in_valid = 1'b1;
         for (int j = 0; j < DIM; j++) bus.in_c[j] = ld[r][j];
         #1;
         chk("load_wren", arr_wren, 1);
         chk("load_crow", arr_crow, r);
         chk("load_en",   arr_en,   0);
         tick();
      end
      bus.in_valid = 1'b0;
      for (int r = 0; r < DIM; r++)
         for (int j = 0; j < DIM; j++) c_exp[r][j] = ld[r][j];
      chk("load_done", done, 1);
      chk("load_err",  err,  0);
   endtask

   // mode 0: beat every cycle, 1: alternate 1,0,1,..., 2: random
   task automatic feed(input int k_len, input int mode, input bit ident, output int cycles);
      int          beats = 0;
      int          cyc = 0;
      bit          v;
      bit          pv = 1'b1;
      logic [31:0] pa = '0, pb = '0;
      logic [31:0] av [DIM];
      logic [31:0] bv [DIM];
      issue(OP_COMPUTE, k_len);
      while (beats < k_len && cyc < 4 * k_len + 20) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         for (int i = 0; i < DIM; i++) begin
            if (ident) begin
               av[i] = (i == beats) ? 32'd1 : 32'd0;
               bv[i] = (i == beats) ? 32'd1 : 32'd0;
            end else begin
               av[i] = $urandom;
               bv[i] = $urandom;
            end
            bus.in_a[i] = av[i];
            bus.in_b[i] = bv[i];
         end
         bus.in_valid = v;
         #1;
         chk("feed_en",    arr_en, v);
         chk("feed_ready", bus.in_ready, 1);
         if (!pv) begin
            chk("skew_hold_a", arr_a[DIM-1], pa);
            chk("skew_hold_b", arr_b[DIM-1], pb);
         end
         pv = v;
         pa = arr_a[DIM-1];
         pb = arr_b[DIM-1];
         if (v) begin
            for (int i = 0; i < DIM; i++)
               for (int j = 0; j < DIM; j++)
                  c_exp[i][j] = c_exp[i][j] + av[i] * bv[j];
            beats++;
         end
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      chk("feed_beats", beats, k_len);
      cycles = cyc;
   endtask

   task automatic drain_wait(output int n);
      n = 0;
      while (!done && n < 100) begin
         chk("drain_en",       arr_en, 1);
         chk("drain_in_ready", bus.in_ready, 0);
         tick();
         n++;
      end
      chk("drain_len", n, 2 * DIM - 1);
   endtask

   task automatic do_read(input bit stall);
      int                  beat = 0;
      int                  st = 0;
      int                  n = 0;
      logic [HD-1:0][31:0] snap_d = '0;
      logic [CW-1:0]       snap_r = '0;
      logic                snap_h = 1'b0;
      for (int r = 0; r < DIM; r++)
         for (int h = 0; h < 2; h++) begin
            beat_t e;
            for (int j = 0; j < HD; j++) e.data[j] = c_exp[r][h * HD + j];
            e.row  = CW'(r);
            e.half = h[0];
            exp_q.push_back(e);
         end
      issue(OP_READ_C, 0);
      while (busy && n < 200) begin
         bus.out_ready = !(stall && beat == 3 && st < 5);
         #1;
         if (!bus.out_ready) begin
            if (st == 0) begin
               snap_d = bus.out_data;
               snap_r = arr_crow;
               snap_h = arr_hl;
            end else begin
               chk("stall_data", bus.out_data, snap_d);
               chk("stall_crow", arr_crow, snap_r);
               chk("stall_hl",   arr_hl,   snap_h);
            end
            st++;
         end
         if (bus.out_valid && bus.out_ready) beat++;
         tick();
         n++;
      end
      bus.out_ready = 1'b0;
      chk("read_beats", beat, 2 * DIM);
      chk("read_done",  done, 1);
      chk("read_queue_empty", exp_q.size(), 0);
   endtask

   task automatic rand_ld();
      for (int r = 0; r < DIM; r++)
         for (int j = 0; j < DIM; j++) ld[r][j] = $urandom;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cyc, n, en_base;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOAD_C;
      bus.cmd_len   = '0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_c      = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",     busy, 0);
      chk("rst_en",       arr_en, 0);
      chk("rst_wren",     arr_wren, 0);
      chk("rst_hl",       arr_hl, 0);
      chk("rst_crow",     arr_crow, 0);
      chk("rst_outvalid", bus.out_valid, 0);
      chk("rst_done",     done, 0);
      chk("rst_err",      err, 0);
      chk("rst_skew",     arr_a[DIM-1], 0);
      rst_n = 1'b1;
      tick();
      chk("idle_cmd_ready", bus.cmd_ready, 1);

      // LOAD_C with row i = {i*8+j}, then read it back
      for (int r = 0; r < DIM; r++)
         for (int j = 0; j < DIM; j++) ld[r][j] = 32'(r * 8 + j);
      do_load();
      tick();
      chk("done_one_cycle", done, 0);
      do_read(1'b0);

      // Identity compute on zero C, read back with a consumer stall
      for (int r = 0; r < DIM; r++)
         for (int j = 0; j < DIM; j++) ld[r][j] = '0;
      do_load();
      feed(8, 0, 1'b1, cyc);
      drain_wait(n);
      chk("identity_latency", cyc + n, 23);
      do_read(1'b1);

      // K=3 with in_valid 1,0,1,0,1
      rand_ld();
      do_load();
      feed(3, 1, 1'b0, cyc);
      chk("toggle_cycles", cyc, 5);
      drain_wait(n);
      do_read(1'b0);

      // Random K and random stall patterns, two accumulating computes per load
      for (int it = 0; it < 3; it++) begin
         rand_ld();
         do_load();
         feed($urandom_range(1, 12), 2, 1'b0, cyc);
         drain_wait(n);
         feed($urandom_range(1, 12), 2, 1'b0, cyc);
         drain_wait(n);
         do_read(it[0]);
      end

      // Reserved op, then back-to-back COMPUTE with K=0
      en_base = en_cycles;
      issue(OP_RSVD, 0);
      chk("rsvd_err",  err, 1);
      chk("rsvd_done", done, 1);
      chk("rsvd_busy", busy, 0);
      issue(OP_COMPUTE, 0);
      chk("len0_done", done, 1);
      chk("len0_err",  err, 0);
      chk("len0_busy", busy, 0);
      tick();
      chk("len0_done_clear", done, 0);
      chk("rsvd_len0_no_en", en_cycles - en_base, 0);

      // Reset in DRAIN when the flush counter reaches 7
      rand_ld();
      do_load();
      feed(2, 0, 1'b0, cyc);
      repeat (8) tick();
      chk("pre_rst_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_en",       arr_en, 0);
      chk("abort_busy",     busy, 0);
      chk("abort_done",     done, 0);
      chk("abort_wren",     arr_wren, 0);
      chk("abort_outvalid", bus.out_valid, 0);
      chk("abort_skew",     arr_a[DIM-1], 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_done", done, 0);
      end
      rand_ld();
      do_load();
      feed($urandom_range(1, 10), 2, 1'b0, cyc);
      drain_wait(n);
      do_read(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
